// File: rtl/traffic_seq_if.sv
`default_nettype none
// ============================================================================
// traffic_seq_if : button inputs and light outputs of the traffic sequencer
// Revision: 1.0
// ============================================================================
interface traffic_seq_if;
    logic       ped_req;
    logic       emergency;
    logic [2:0] color;
    logic       ped_wait;

    modport master (
        output ped_req,
        output emergency,
        input  color,
        input  ped_wait
    );

    modport slave (
        input  ped_req,
        input  emergency,
        output color,
        output ped_wait
    );
endinterface
`default_nettype wire

// File: rtl/traffic_seq.sv
`default_nettype none
// ============================================================================
// traffic_seq : timed S1..S8 light sequencer with pedestrian latch and
//               emergency all-red override.
// Revision: 1.0
// ============================================================================
module traffic_seq #(
    parameter int CLK_DIV   = 100_000_000,
    parameter int T_SANTA_G = 10,
    parameter int T_INT_G   = 10,
    parameter int T_PED_G   = 8,
    parameter int T_YEL     = 3,
    parameter int T_ALLRED  = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    traffic_seq_if.slave bus
);

    localparam int C_T_M1  = (T_SANTA_G > T_INT_G) ? T_SANTA_G : T_INT_G;
    localparam int C_T_M2  = (T_PED_G > T_YEL) ? T_PED_G : T_YEL;
    localparam int C_T_M3  = (C_T_M1 > C_T_M2) ? C_T_M1 : C_T_M2;
    localparam int C_T_MAX = (C_T_M3 > T_ALLRED) ? C_T_M3 : T_ALLRED;
    localparam int PW      = $clog2(CLK_DIV);
    localparam int TW      = (C_T_MAX > 1) ? $clog2(C_T_MAX) : 1;

    localparam logic [PW-1:0] C_PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S1_SANTA_G = 3'b000,
        S2_SANTA_Y = 3'b001,
        S3_INT_G   = 3'b010,
        S4_INT_Y   = 3'b011,
        S5_PED_G   = 3'b100,
        S6_PED_Y   = 3'b101,
        S7_ALL_RED = 3'b110,
        S8_EMERG   = 3'b111
    } state_t;

    state_t        r_state;
    logic          r_dir;
    logic          r_pend;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_ped_sync;
    logic [1:0]    r_emg_sync;

    state_t        w_state_nxt;
    logic          w_dir_nxt;
    logic          w_pend_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [TW-1:0] w_tick_nxt;
    logic [TW-1:0] w_tick_last;
    logic          w_presc_last;
    logic          w_expire;
    logic          w_enter;
    logic          w_ped_s;
    logic          w_emg_s;

    assign w_ped_s = r_ped_sync[1];
    assign w_emg_s = r_emg_sync[1];

    always_comb begin
        w_tick_last = '0;
        case (r_state)
            S1_SANTA_G: w_tick_last = TW'(T_SANTA_G - 1);
            S2_SANTA_Y,
            S4_INT_Y,
            S6_PED_Y:   w_tick_last = TW'(T_YEL - 1);
            S3_INT_G:   w_tick_last = TW'(T_INT_G - 1);
            S5_PED_G:   w_tick_last = TW'(T_PED_G - 1);
            S7_ALL_RED: w_tick_last = TW'(T_ALLRED - 1);
            default:    w_tick_last = '0;
        endcase
    end

    assign w_presc_last = (r_presc == C_PRESC_LAST);
    assign w_expire     = w_presc_last && (r_tick == w_tick_last) && (r_state != S8_EMERG);

    // Emergency outranks everything, then S8 release, then normal expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        if (w_emg_s) begin
            w_state_nxt = S8_EMERG;
        end else if (r_state == S8_EMERG) begin
            w_state_nxt = S7_ALL_RED;
            w_dir_nxt   = 1'b0;
        end else if (w_expire) begin
            case (r_state)
                S1_SANTA_G: w_state_nxt = S2_SANTA_Y;
                S2_SANTA_Y: begin
                    w_state_nxt = S7_ALL_RED;
                    w_dir_nxt   = 1'b1;
                end
                S3_INT_G:   w_state_nxt = S4_INT_Y;
                S4_INT_Y: begin
                    w_state_nxt = S7_ALL_RED;
                    w_dir_nxt   = 1'b0;
                end
                S5_PED_G:   w_state_nxt = S6_PED_Y;
                S6_PED_Y: begin
                    w_state_nxt = S7_ALL_RED;
                    w_dir_nxt   = 1'b0;
                end
                S7_ALL_RED: begin
                    if (!r_dir)
                        w_state_nxt = S1_SANTA_G;
                    else if (r_pend)
                        w_state_nxt = S5_PED_G;
                    else
                        w_state_nxt = S3_INT_G;
                end
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    assign w_enter = (w_state_nxt != r_state);

    always_comb begin
        w_presc_nxt = r_presc;
        w_tick_nxt  = r_tick;
        if (w_enter || (r_state == S8_EMERG)) begin
            w_presc_nxt = '0;
            w_tick_nxt  = '0;
        end else if (w_presc_last) begin
            w_presc_nxt = '0;
            w_tick_nxt  = r_tick + TW'(1);
        end else begin
            w_presc_nxt = r_presc + PW'(1);
        end
    end

    // Clear on entry into S5 is applied last so it wins over a same-cycle set.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_ped_s && (r_state != S5_PED_G) && (r_state != S6_PED_Y))
            w_pend_nxt = 1'b1;
        if ((w_state_nxt == S5_PED_G) && (r_state != S5_PED_G))
            w_pend_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S7_ALL_RED;
            r_dir      <= 1'b0;
            r_pend     <= 1'b0;
            r_presc    <= '0;
            r_tick     <= '0;
            r_ped_sync <= '0;
            r_emg_sync <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_pend     <= w_pend_nxt;
            r_presc    <= w_presc_nxt;
            r_tick     <= w_tick_nxt;
            r_ped_sync <= {r_ped_sync[0], bus.ped_req};
            r_emg_sync <= {r_emg_sync[0], bus.emergency};
        end
    end

    assign bus.color    = r_state;
    assign bus.ped_wait = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_traffic_seq.sv
`default_nettype none
// ============================================================================
// tb_traffic_seq : directed scenarios plus random stimulus for traffic_seq
// Revision: 1.0
// ============================================================================
module tb_traffic_seq;

    localparam int CLK_DIV   = 4;
    localparam int T_SANTA_G = 3;
    localparam int T_INT_G   = 3;
    localparam int T_PED_G   = 2;
    localparam int T_YEL     = 2;
    localparam int T_ALLRED  = 1;

    logic clk = 1'b0;
    logic rst_n;

    traffic_seq_if bus ();

    traffic_seq #(
        .CLK_DIV   (CLK_DIV),
        .T_SANTA_G (T_SANTA_G),
        .T_INT_G   (T_INT_G),
        .T_PED_G   (T_PED_G),
        .T_YEL     (T_YEL),
        .T_ALLRED  (T_ALLRED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: phase code plus remaining dwell cycles, inputs delayed two edges.
    int       m_phase;
    int       m_left;
    bit       m_dir;
    bit       m_pend;
    bit [1:0] m_hp;
    bit [1:0] m_he;
    bit       emg_on;

    typedef struct {
        bit         ped;
        bit         emg;
        logic [2:0] color;
        bit         pw;
        int         n;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dwell(input int ph);
        case (ph)
            0:       return T_SANTA_G * CLK_DIV;
            1, 3, 5: return T_YEL * CLK_DIV;
            2:       return T_INT_G * CLK_DIV;
            4:       return T_PED_G * CLK_DIV;
            6:       return T_ALLRED * CLK_DIV;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 6;
        m_left  = dwell(6);
        m_dir   = 1'b0;
        m_pend  = 1'b0;
        m_hp    = '0;
        m_he    = '0;
    endtask

    task automatic model_edge(input bit ped, input bit emg);
        bit ped_s;
        bit emg_s;
        int nxt;
        ped_s = m_hp[1];
        emg_s = m_he[1];
        nxt   = m_phase;
        if (emg_s) begin
            nxt = 7;
        end else if (m_phase == 7) begin
            nxt   = 6;
            m_dir = 1'b0;
        end else if (m_left == 1) begin
            case (m_phase)
                0: nxt = 1;
                1: begin nxt = 6; m_dir = 1'b1; end
                2: nxt = 3;
                3: begin nxt = 6; m_dir = 1'b0; end
                4: nxt = 5;
                5: begin nxt = 6; m_dir = 1'b0; end
                6: nxt = m_dir ? (m_pend ? 4 : 2) : 0;
                default: nxt = m_phase;
            endcase
        end
        if (ped_s && m_phase != 4 && m_phase != 5) m_pend = 1'b1;
        if (nxt == 4 && m_phase != 4) m_pend = 1'b0;
        if (nxt != m_phase) m_left = dwell(nxt);
        else if (m_phase != 7) m_left = m_left - 1;
        m_phase = nxt;
        m_hp = {m_hp[0], ped};
        m_he = {m_he[0], emg};
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge(bus.ped_req, bus.emergency);
        #1;
        check("model_color", int'(bus.color), m_phase);
        check("model_ped_wait", int'(bus.ped_wait), int'(m_pend));
    endtask

    task automatic expect_phase(input logic [2:0] c, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, int'(bus.color), int'(c));
        end
    endtask

    task automatic async_reset();
        #2;
        rst_n         = 1'b0;
        bus.ped_req   = 1'b0;
        bus.emergency = 1'b0;
        #1;
        check("rst_color_now", int'(bus.color), 6);
        check("rst_ped_wait_now", int'(bus.ped_wait), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rel_color", int'(bus.color), 6);
    endtask

    task automatic run_table();
        for (int i = 0; i < 8; i++) begin
            bus.ped_req   = tbl[i].ped;
            bus.emergency = tbl[i].emg;
            for (int j = 0; j < tbl[i].n; j++) begin
                step();
                check("tbl_color", int'(bus.color), int'(tbl[i].color));
                check("tbl_ped_wait", int'(bus.ped_wait), int'(tbl[i].pw));
            end
        end
    endtask

    initial begin
        // Idle cycle after reset release; the first S7 period is the release cycle.
        tbl[0] = '{1'b0, 1'b0, 3'b110, 1'b0, 3};
        tbl[1] = '{1'b0, 1'b0, 3'b000, 1'b0, 12};
        tbl[2] = '{1'b0, 1'b0, 3'b001, 1'b0, 8};
        tbl[3] = '{1'b0, 1'b0, 3'b110, 1'b0, 4};
        tbl[4] = '{1'b0, 1'b0, 3'b010, 1'b0, 12};
        tbl[5] = '{1'b0, 1'b0, 3'b011, 1'b0, 8};
        tbl[6] = '{1'b0, 1'b0, 3'b110, 1'b0, 4};
        tbl[7] = '{1'b0, 1'b0, 3'b000, 1'b0, 1};

        rst_n         = 1'b0;
        bus.ped_req   = 1'b0;
        bus.emergency = 1'b0;
        emg_on        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_color", int'(bus.color), 6);
        check("reset_ped_wait", int'(bus.ped_wait), 0);
        #2;
        rst_n = 1'b1;
        #1;
        check("release_color", int'(bus.color), 6);

        run_table();

        // Pedestrian request served
        bus.ped_req = 1'b1;
        expect_phase(3'b000, 1, "ped_s1");
        bus.ped_req = 1'b0;
        expect_phase(3'b000, 1, "ped_s1");
        check("ped_wait_k1", int'(bus.ped_wait), 0);
        expect_phase(3'b000, 1, "ped_s1");
        check("ped_wait_k2", int'(bus.ped_wait), 1);
        expect_phase(3'b000, 8, "ped_s1");
        expect_phase(3'b001, 8, "ped_s2");
        expect_phase(3'b110, 4, "ped_s7");
        check("ped_wait_before_s5", int'(bus.ped_wait), 1);
        expect_phase(3'b100, 1, "ped_s5");
        check("ped_wait_clear_s5", int'(bus.ped_wait), 0);
        expect_phase(3'b100, 7, "ped_s5");
        expect_phase(3'b101, 8, "ped_s6");
        expect_phase(3'b110, 4, "ped_s7b");
        expect_phase(3'b000, 1, "ped_s1b");

        // Request during S5 ignored
        bus.ped_req = 1'b1;
        expect_phase(3'b000, 1, "ign_s1");
        bus.ped_req = 1'b0;
        expect_phase(3'b000, 10, "ign_s1");
        expect_phase(3'b001, 8, "ign_s2");
        expect_phase(3'b110, 4, "ign_s7");
        expect_phase(3'b100, 1, "ign_s5");
        bus.ped_req = 1'b1;
        expect_phase(3'b100, 1, "ign_s5");
        bus.ped_req = 1'b0;
        expect_phase(3'b100, 6, "ign_s5");
        check("ign_ped_wait_s5", int'(bus.ped_wait), 0);
        expect_phase(3'b101, 8, "ign_s6");
        expect_phase(3'b110, 4, "ign_s7b");
        expect_phase(3'b000, 12, "ign_s1b");
        expect_phase(3'b001, 8, "ign_s2b");
        expect_phase(3'b110, 4, "ign_s7c");
        expect_phase(3'b010, 1, "ign_s3");
        check("ign_ped_wait_s3", int'(bus.ped_wait), 0);

        // Emergency mid-dwell in S3
        expect_phase(3'b010, 2, "emg_s3");
        bus.emergency = 1'b1;
        expect_phase(3'b010, 2, "emg_lat");
        expect_phase(3'b111, 18, "emg_s8");
        bus.emergency = 1'b0;
        expect_phase(3'b111, 2, "emg_rel_lat");
        expect_phase(3'b110, 4, "emg_s7");
        expect_phase(3'b000, 12, "emg_s1");

        // Emergency together with a pedestrian request
        bus.ped_req   = 1'b1;
        bus.emergency = 1'b1;
        expect_phase(3'b001, 1, "ep_s2");
        bus.ped_req = 1'b0;
        expect_phase(3'b001, 1, "ep_s2");
        expect_phase(3'b111, 1, "ep_s8");
        check("ep_ped_wait_enter", int'(bus.ped_wait), 1);
        expect_phase(3'b111, 7, "ep_s8");
        bus.emergency = 1'b0;
        expect_phase(3'b111, 2, "ep_s8_rel");
        check("ep_ped_wait_held", int'(bus.ped_wait), 1);
        expect_phase(3'b110, 4, "ep_s7");
        expect_phase(3'b000, 12, "ep_s1");
        expect_phase(3'b001, 8, "ep_s2b");
        expect_phase(3'b110, 4, "ep_s7b");
        expect_phase(3'b100, 1, "ep_s5");
        check("ep_ped_wait_s5", int'(bus.ped_wait), 0);

        // Async reset mid-S4, then the idle cycle again
        expect_phase(3'b100, 7, "ar_s5");
        expect_phase(3'b101, 8, "ar_s6");
        expect_phase(3'b110, 4, "ar_s7");
        expect_phase(3'b000, 12, "ar_s1");
        expect_phase(3'b001, 8, "ar_s2");
        expect_phase(3'b110, 4, "ar_s7b");
        expect_phase(3'b010, 12, "ar_s3");
        expect_phase(3'b011, 3, "ar_s4");
        async_reset();
        run_table();

        // Random traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            bus.ped_req = ($urandom_range(0, 11) == 0);
            if (emg_on) emg_on = ($urandom_range(0, 15) != 0);
            else        emg_on = ($urandom_range(0, 299) == 0);
            bus.emergency = emg_on;
            if ($urandom_range(0, 1499) == 0) async_reset();
            else                              step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
